// File: rtl/ysyx_23060180_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060180_mem_pkg
// Description : Shared types and constants for the memory-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_23060180_mem_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Requester ids; also the bit positions in the request/grant vectors
  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  // Read data returned when a memory access times out
  localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060180_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060180_rr_arb2
// Description : Two-way combinational arbiter producing a one-hot grant.
//               Ties go to LSU under fixed priority, otherwise to the
//               requester that did not win last time.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060180_rr_arb2
  import ysyx_23060180_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic [1:0] grant
);

  // A lone requester always wins; ties resolved by priority mode
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      if (fixed_prio || (last_grant == REQ_IFU)) begin
        grant = 2'b10;
      end else begin
        grant = 2'b01;
      end
    end else begin
      grant = req;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060180_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060180_mem_arbiter
// Description : Shares the single memory port between IFU and LSU. Accepts
//               one request at a time, holds it on the memory port until
//               acknowledged (or timed out), then pulses a one-cycle response
//               to the winning requester.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060180_mem_arbiter
  import ysyx_23060180_mem_pkg::*;
#(
  parameter logic        LSU_PRIORITY = 1'b0,
  parameter logic [15:0] TIMEOUT      = 16'd255,
  parameter logic [31:0] ERR_RDATA    = DEFAULT_ERR_RDATA
) (
  input  logic        clk,
  input  logic        rstn_in,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        ifu_rsp_valid,
  output logic        lsu_rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [1:0]  w_req;
  logic [1:0]  w_grant;
  logic        w_accept;
  logic        r_last_grant;   // doubles as the owner of the in-flight request
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic [15:0] r_tmo_cnt;
  logic [15:0] w_cnt_inc;
  logic        w_cnt_hit;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  assign w_req     = {lsu_req_valid, ifu_req_valid};
  assign w_accept  = (r_state == ST_IDLE) && (w_req != 2'b00);
  assign w_cnt_inc = r_tmo_cnt + 16'd1;
  // Timeout fires only when no ack arrives in the same cycle
  assign w_cnt_hit = (w_cnt_inc == TIMEOUT) && !mem_ack;

  ysyx_23060180_rr_arb2 u_arb (
    .req        (w_req),
    .last_grant (r_last_grant),
    .fixed_prio (LSU_PRIORITY),
    .grant      (w_grant)
  );

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  // State register; reset drops mem_req at once since it decodes from state
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake/strobe outputs
  always_comb begin
    w_state_nxt   = r_state;
    mem_req       = 1'b0;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    lsu_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ifu_req_ready = w_grant[REQ_IFU];
        lsu_req_ready = w_grant[REQ_LSU];
        if (w_accept) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        mem_req = 1'b1;
        if (mem_ack || w_cnt_hit) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        ifu_rsp_valid = (r_last_grant == REQ_IFU);
        lsu_rsp_valid = (r_last_grant == REQ_LSU);
        w_state_nxt   = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request latch on acceptance, timeout counting and response capture
  always_ff @(posedge clk or negedge rstn_in) begin
    if (!rstn_in) begin
      r_last_grant <= REQ_LSU;
      r_we         <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_wmask      <= 4'd0;
      r_tmo_cnt    <= 16'd0;
      r_rsp_rdata  <= 32'd0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_last_grant <= w_grant[REQ_LSU];
            r_tmo_cnt    <= 16'd0;
            if (w_grant[REQ_LSU]) begin
              r_addr  <= lsu_addr;
              r_we    <= lsu_wen;
              r_wdata <= lsu_wdata;
              r_wmask <= lsu_wmask;
            end else begin
              r_addr  <= ifu_addr;
              r_we    <= 1'b0;
              r_wdata <= 32'd0;
              r_wmask <= 4'd0;
            end
          end
        end
        ST_WAIT: begin
          if (mem_ack) begin
            r_rsp_rdata <= r_we ? 32'd0 : mem_rdata;
            r_rsp_err   <= 1'b0;
          end else begin
            r_tmo_cnt <= w_cnt_inc;
            if (w_cnt_hit) begin
              r_rsp_rdata <= ERR_RDATA;
              r_rsp_err   <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060180_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060180_mem_arbiter
// Description : Directed self-checking bench. dut0 is round-robin, dut1 is
//               LSU-priority; both use TIMEOUT=4 and share all inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060180_mem_arbiter;

  logic        clk;
  logic        rstn_in;
  logic        ifu_req_valid, lsu_req_valid, lsu_wen, mem_ack;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
  logic [3:0]  lsu_wmask;

  logic        ifu_req_ready, lsu_req_ready, ifu_rsp_valid, lsu_rsp_valid;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata;
  logic        rsp_err, mem_req, mem_we;
  logic [3:0]  mem_wmask;

  logic        p_ifu_req_ready, p_lsu_req_ready, p_ifu_rsp_valid, p_lsu_rsp_valid;
  logic [31:0] p_rsp_rdata, p_mem_addr, p_mem_wdata;
  logic        p_rsp_err, p_mem_req, p_mem_we;
  logic [3:0]  p_mem_wmask;

  int n_chk;
  int n_pass;

  ysyx_23060180_mem_arbiter #(.LSU_PRIORITY(1'b0), .TIMEOUT(16'd4)) dut0 (
    .clk(clk), .rstn_in(rstn_in),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .ifu_rsp_valid(ifu_rsp_valid), .lsu_rsp_valid(lsu_rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  ysyx_23060180_mem_arbiter #(.LSU_PRIORITY(1'b1), .TIMEOUT(16'd4)) dut1 (
    .clk(clk), .rstn_in(rstn_in),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(p_ifu_req_ready), .ifu_addr(ifu_addr),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(p_lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .ifu_rsp_valid(p_ifu_rsp_valid), .lsu_rsp_valid(p_lsu_rsp_valid),
    .rsp_rdata(p_rsp_rdata), .rsp_err(p_rsp_err),
    .mem_req(p_mem_req), .mem_we(p_mem_we), .mem_addr(p_mem_addr),
    .mem_wdata(p_mem_wdata), .mem_wmask(p_mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rstn_in = 1'b0;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; lsu_wen = 1'b0; mem_ack = 1'b0;
    ifu_addr = 32'd0; lsu_addr = 32'd0; lsu_wdata = 32'd0; lsu_wmask = 4'd0;
    mem_rdata = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk("rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst ifu_rsp", {31'd0, ifu_rsp_valid}, 32'd0);
    chk("rst lsu_rsp", {31'd0, lsu_rsp_valid}, 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    chk("rst err", {31'd0, rsp_err}, 32'd0);
    chk("rst addr", mem_addr, 32'd0);
    chk("rst ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
    nxt();
    rstn_in = 1'b1;
    nxt();

    // IFU read, ack in cycle 1
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    #1;
    chk("ifu ready", {31'd0, ifu_req_ready}, 32'd1);
    chk("ifu lsu_ready", {31'd0, lsu_req_ready}, 32'd0);
    nxt();
    ifu_req_valid = 1'b0; ifu_addr = 32'd0; mem_ack = 1'b1; mem_rdata = 32'h0010_0093;
    #1;
    chk("ifu mem_req", {31'd0, mem_req}, 32'd1);
    chk("ifu mem_addr", mem_addr, 32'h8000_0000);
    chk("ifu mem_we", {31'd0, mem_we}, 32'd0);
    nxt();
    mem_ack = 1'b0; mem_rdata = 32'd0;
    #1;
    chk("ifu rsp", {31'd0, ifu_rsp_valid}, 32'd1);
    chk("ifu lsu_rsp", {31'd0, lsu_rsp_valid}, 32'd0);
    chk("ifu rdata", rsp_rdata, 32'h0010_0093);
    chk("ifu err", {31'd0, rsp_err}, 32'd0);
    chk("ifu resp mem_req", {31'd0, mem_req}, 32'd0);
    nxt();
    #1;
    chk("ifu rsp once", {31'd0, ifu_rsp_valid}, 32'd0);
    chk("ifu rdata hold", rsp_rdata, 32'h0010_0093);

    // LSU write, ack after 3 wait cycles
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0100;
    lsu_wdata = 32'h1234_5678; lsu_wmask = 4'b0011;
    #1;
    chk("lsu ready", {31'd0, lsu_req_ready}, 32'd1);
    chk("lsu ifu_ready", {31'd0, ifu_req_ready}, 32'd0);
    nxt();
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = 32'd0; lsu_wdata = 32'd0; lsu_wmask = 4'd0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("lsu mem_req", {31'd0, mem_req}, 32'd1);
      chk("lsu mem_we", {31'd0, mem_we}, 32'd1);
      chk("lsu mem_addr", mem_addr, 32'h8000_0100);
      chk("lsu mem_wdata", mem_wdata, 32'h1234_5678);
      chk("lsu mem_wmask", {28'd0, mem_wmask}, 32'h3);
      chk("lsu early rsp", {31'd0, lsu_rsp_valid}, 32'd0);
      nxt();
      #1;
    end
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("lsu ack mem_req", {31'd0, mem_req}, 32'd1);
    nxt();
    mem_ack = 1'b0;
    #1;
    chk("lsu rsp", {31'd0, lsu_rsp_valid}, 32'd1);
    chk("lsu ifu_rsp", {31'd0, ifu_rsp_valid}, 32'd0);
    chk("lsu rdata", rsp_rdata, 32'd0);
    chk("lsu err", {31'd0, rsp_err}, 32'd0);
    nxt();
    #1;
    chk("lsu rsp once", {31'd0, lsu_rsp_valid}, 32'd0);

    // Continuous tie: dut0 alternates starting with IFU, dut1 always LSU
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0200; lsu_addr = 32'h8000_0300;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr ifu_ready", {31'd0, ifu_req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr lsu_ready", {31'd0, lsu_req_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk("pri lsu_ready", {31'd0, p_lsu_req_ready}, 32'd1);
      chk("pri ifu_ready", {31'd0, p_ifu_req_ready}, 32'd0);
      nxt();
      mem_ack = 1'b1; mem_rdata = 32'h100 + i;
      #1;
      chk("rr wait ready", {30'd0, ifu_req_ready, lsu_req_ready}, 32'd0);
      chk("rr mem_addr", mem_addr, (i % 2 == 0) ? 32'h8000_0200 : 32'h8000_0300);
      nxt();
      mem_ack = 1'b0;
      #1;
      chk("rr ifu_rsp", {31'd0, ifu_rsp_valid}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("pri lsu_rsp", {31'd0, p_lsu_rsp_valid}, 32'd1);
      chk("rr rdata", rsp_rdata, 32'h100 + i);
      nxt();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // Timeout with no ack
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
    #1;
    chk("tmo ready", {31'd0, ifu_req_ready}, 32'd1);
    nxt();
    ifu_req_valid = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      #1;
      chk("tmo mem_req", {31'd0, mem_req}, 32'd1);
      chk("tmo early rsp", {31'd0, ifu_rsp_valid}, 32'd0);
      nxt();
    end
    #1;
    chk("tmo mem_req drop", {31'd0, mem_req}, 32'd0);
    chk("tmo rsp", {31'd0, ifu_rsp_valid}, 32'd1);
    chk("tmo err", {31'd0, rsp_err}, 32'd1);
    chk("tmo rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("pri tmo err", {31'd0, p_rsp_err}, 32'd1);
    nxt();
    #1;
    chk("tmo rsp once", {31'd0, ifu_rsp_valid}, 32'd0);
    chk("tmo err hold", {31'd0, rsp_err}, 32'd1);

    // Ack on the 4th wait cycle beats the timeout
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0014;
    #1;
    nxt();
    ifu_req_valid = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      #1;
      chk("ackw mem_req", {31'd0, mem_req}, 32'd1);
      nxt();
    end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    #1;
    chk("ackw mem_req 4", {31'd0, mem_req}, 32'd1);
    nxt();
    mem_ack = 1'b0;
    #1;
    chk("ackw rsp", {31'd0, ifu_rsp_valid}, 32'd1);
    chk("ackw err", {31'd0, rsp_err}, 32'd0);
    chk("ackw rdata", rsp_rdata, 32'hCAFE_0001);
    nxt();

    // Stray ack in IDLE
    mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
    #1;
    chk("idle ack mem_req", {31'd0, mem_req}, 32'd0);
    nxt();
    #1;
    chk("idle ack rsp", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
    chk("idle ack rdata", rsp_rdata, 32'hCAFE_0001);
    mem_ack = 1'b0;
    nxt();

    // Ack held high through RESP
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0018;
    #1;
    nxt();
    ifu_req_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0AAA;
    #1;
    nxt();
    mem_rdata = 32'h0000_0BBB;
    #1;
    chk("resp ack rsp", {31'd0, ifu_rsp_valid}, 32'd1);
    chk("resp ack rdata", rsp_rdata, 32'h0000_0AAA);
    nxt();
    #1;
    chk("resp ack extra rsp", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
    chk("resp ack mem_req", {31'd0, mem_req}, 32'd0);
    chk("resp ack rdata hold", rsp_rdata, 32'h0000_0AAA);
    mem_ack = 1'b0;
    nxt();

    // Reset during WAIT of an IFU request (leaves last_grant = IFU otherwise)
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_001C;
    #1;
    nxt();
    ifu_req_valid = 1'b0;
    #1;
    chk("rstw mem_req", {31'd0, mem_req}, 32'd1);
    nxt();
    rstn_in = 1'b0;
    #1;
    chk("rstw mem_req drop", {31'd0, mem_req}, 32'd0);
    chk("rstw pri mem_req drop", {31'd0, p_mem_req}, 32'd0);
    chk("rstw rsp", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
    nxt();
    #1;
    chk("rstw rsp 2", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
    rstn_in = 1'b1;
    nxt();
    #1;
    chk("rstw rsp 3", {30'd0, ifu_rsp_valid, lsu_rsp_valid}, 32'd0);
    chk("rstw rdata", rsp_rdata, 32'd0);
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    #1;
    chk("rstw tie ifu", {31'd0, ifu_req_ready}, 32'd1);
    chk("rstw tie lsu", {31'd0, lsu_req_ready}, 32'd0);
    chk("rstw pri tie lsu", {31'd0, p_lsu_req_ready}, 32'd1);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_23060180_mem_arbiter.md
# ysyx_23060180_mem_arbiter

Two-requester arbiter and sequencer for the core's single memory port. It shares that port between the instruction-fetch side (IFU) and the load/store side (LSU). It accepts one request at a time, holds the request to memory until the memory acknowledges, and returns a single-cycle response to the requester that won. A timeout turns a hung memory access into an error response.

## Interface
- `LSU_PRIORITY`, default 0: 1 = LSU always wins ties; 0 = round-robin.
- `TIMEOUT`, default 255: max WAIT cycles without `mem_ack` before an error response; 16-bit counter, must be ≥1.
- `ERR_RDATA`, default 32'hDEAD_BEEF: `rdata` returned on timeout.
- `clk` input 1: clock.
- `rstn_in` input 1: reset, asynchronous, active-low.
- `ifu_req_valid` / `lsu_req_valid` input 1: request pending.
- `ifu_req_ready` / `lsu_req_ready` output 1: request accepted this cycle.
- `ifu_addr` / `lsu_addr` input 32: byte address.
- `lsu_wen` input 1: write (1) / read (0); IFU is read-only.
- `lsu_wdata` input 32, `lsu_wmask` input 4: write data and byte enables.
- `ifu_rsp_valid` / `lsu_rsp_valid` output 1: one-cycle response pulse.
- `rsp_rdata` output 32, `rsp_err` output 1: shared response payload, valid with either `rsp_valid`.
- `mem_req` output 1, `mem_we` output 1, `mem_addr` output 32, `mem_wdata` output 32, `mem_wmask` output 4: downstream request.
- `mem_ack` input 1, `mem_rdata` input 32: downstream completion; `mem_rdata` is valid in the `mem_ack` cycle.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: if any `req_valid`, pick the winner and assert only the winner's `req_ready` (combinational). Latch addr, wen (forced 0 for IFU), wdata, wmask (forced 0 for IFU) and the owner id. Clear the timeout counter. Go to WAIT.
- WAIT: `mem_req`=1 and `mem_*` driven from the latched request, held stable every cycle.
  - `mem_ack`=1: latch `mem_rdata` (write: latch 0), `err`=0, go to RESP.
  - Otherwise the counter increments. When it reaches `TIMEOUT`: latch `ERR_RDATA`, `err`=1, go to RESP.
  - If `mem_ack` arrives in the same cycle the counter hits `TIMEOUT`, the ack wins.
- RESP: the owner's `rsp_valid`=1 for exactly one cycle with latched `rsp_rdata`/`rsp_err`, then IDLE.
  - No response backpressure; requesters must take the pulse.
  - `mem_req`=0 in this state.
- Arbitration, round-robin: `last_grant` register, reset to LSU, so the first tie goes to IFU. It updates only on acceptance. A lone requester always wins.
- Arbitration, `LSU_PRIORITY`=1: LSU wins every tie.
- Requests are ignored outside IDLE (`req_ready`=0). Inputs need not be held after acceptance.
- `mem_ack` outside WAIT is ignored.
- Reset at any point:
  - State returns to IDLE.
  - `mem_req` drops immediately; no response is issued for the in-flight request.
  - `last_grant` is set to LSU; counter cleared.

## Timing
- Reset values: all outputs 0, except `ifu_req_ready`/`lsu_req_ready`, which follow the combinational grant in IDLE.
- Accept at cycle 0 → `mem_req` high from cycle 1. With `mem_ack` at cycle k≥1, `rsp_valid` at k+1. Next acceptance possible at k+2.
- Minimum request-to-response latency: 2 cycles (ack in cycle 1). Peak throughput: one transaction per 3 cycles.
- Timeout with no ack: `mem_req` high for cycles 1..`TIMEOUT`, `rsp_err` pulse at `TIMEOUT`+1.
- `rsp_rdata`/`rsp_err` stay registered (hold last value) outside RESP.

## Structure
- Package `ysyx_23060180_mem_pkg`:
  - state enum (IDLE/WAIT/RESP);
  - requester id constants `REQ_IFU`=0, `REQ_LSU`=1;
  - default `ERR_RDATA`.
- Sub-module `ysyx_23060180_rr_arb2`: 2-way combinational grant from (`req[1:0]`, `last_grant`, `fixed_prio`) → one-hot grant. The parent owns the `last_grant` register.

## Test plan
- IFU read, addr 32'h8000_0000, `mem_ack` in cycle 1 with 32'h0010_0093 → `ifu_rsp_valid` at cycle 2, `rsp_rdata`=32'h0010_0093, `rsp_err`=0; `lsu_rsp_valid` stays 0.
- LSU write, addr 32'h8000_0100, wdata 32'h1234_5678, wmask 4'b0011, ack after 3 wait cycles → `mem_we`=1 and all `mem_*` stable for 3 cycles; `lsu_rsp_valid` one cycle after ack, `rsp_rdata`=0.
- Both requesters valid continuously, round-robin → grants IFU, LSU, IFU, LSU. With `LSU_PRIORITY`=1 → LSU, LSU, LSU.
- `TIMEOUT`=4, no ack → `mem_req` high exactly 4 cycles, then response pulse with `rsp_err`=1, `rsp_rdata`=32'hDEAD_BEEF. Repeat with ack on the 4th wait cycle → `rsp_err`=0, real data.
- `rstn_in` asserted in WAIT → `mem_req`=0 immediately, no `rsp_valid`. After release, a tie grants IFU first.
- `mem_ack` pulsed in IDLE and RESP → no state change, no extra response.
